// File: rtl/music_box_ui_pkg.sv
// Shared types and constants for the music box front-panel input smoothers.
package music_box_ui_pkg;

    // Per-channel debounce state.
    typedef enum logic [1:0] {
        IDLE,
        PRESS_PENDING,
        PRESSED,
        RELEASE_PENDING
    } ui_chan_state_t;

    // Defaults for a 50 MHz clock: 1 ms tick, 5 ms debounce, 1 s long press.
    localparam int unsigned UI_CLK_PER_TICK_1MS = 50000;
    localparam int unsigned UI_DEBOUNCE_TICKS   = 5;
    localparam int unsigned UI_HOLD_TICKS       = 1000;

    // Front-panel channel assignment.
    localparam int unsigned UI_CH_KEY0           = 0;
    localparam int unsigned UI_CH_KEY1           = 1;
    localparam int unsigned UI_CH_KEY2           = 2;
    localparam int unsigned UI_CH_KEY3           = 3;
    localparam int unsigned UI_CH_KEY4           = 4;
    localparam int unsigned UI_CH_KEY5           = 5;
    localparam int unsigned UI_CH_PLAY_SONG0     = 6;
    localparam int unsigned UI_CH_PLAY_SONG1     = 7;
    localparam int unsigned UI_CH_MAKE_RECORDING = 8;
    localparam int unsigned UI_CH_PLAY_RECORDING = 9;
    localparam int unsigned UI_NUM_CHANNELS      = 10;

    // A channel reports "pressed" once the press is confirmed and until the release is.
    function automatic logic ui_level_of(ui_chan_state_t st);
        return (st == PRESSED) || (st == RELEASE_PENDING);
    endfunction

endpackage

// File: rtl/ui_debounce_channel.sv
// One input channel: two-flop synchroniser, debounce FSM, hold counter and
// registered level / press / release / hold outputs.
module ui_debounce_channel
    import music_box_ui_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = UI_DEBOUNCE_TICKS,
    parameter int unsigned HOLD_TICKS     = UI_HOLD_TICKS,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic level_d_o,
    output logic press_o,
    output logic release_o,
    output logic hold_o
);

    localparam int unsigned DebW  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned HoldW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    logic [1:0]     sync_d, sync_q;
    logic           sample;
    ui_chan_state_t state_d, state_q;
    logic [DebW-1:0] cnt_d, cnt_q, cnt_inc;
    logic           level_d, level_q;
    logic           press_d, press_q;
    logic           release_d, release_q;

    // Synchroniser shift and polarity normalisation (sample = 1 means pressed).
    always_comb begin
        sync_d = {sync_q[0], raw_i};
        sample = sync_q[1] ^ ACTIVE_LOW;
    end

    // Debounce FSM: a reversal of the sample always wins over a coincident tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + DebW'(1);
        case (state_q)
            IDLE: begin
                if (sample) begin
                    state_d = PRESS_PENDING;
                    cnt_d   = '0;
                end
            end
            PRESS_PENDING: begin
                if (!sample) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    if (cnt_inc == DebW'(DEBOUNCE_TICKS)) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            PRESSED: begin
                if (!sample) begin
                    state_d = RELEASE_PENDING;
                    cnt_d   = '0;
                end
            end
            RELEASE_PENDING: begin
                if (sample) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    if (cnt_inc == DebW'(DEBOUNCE_TICKS)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered level and edge pulses, derived from the next state.
    always_comb begin
        level_d   = ui_level_of(state_d);
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
    end

    // State, synchroniser and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= {2{ACTIVE_LOW}};
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    if (HOLD_TICKS > 0) begin : g_hold
        logic [HoldW-1:0] hold_cnt_d, hold_cnt_q;
        logic             hold_pulse_d, hold_pulse_q;

        // Hold counter saturates, so the pulse fires once per press.
        always_comb begin
            hold_cnt_d = hold_cnt_q;
            if (state_d == IDLE) begin
                hold_cnt_d = '0;
            end else if (tick_i && level_q && (hold_cnt_q != HoldW'(HOLD_TICKS))) begin
                hold_cnt_d = hold_cnt_q + HoldW'(1);
            end
            hold_pulse_d = (hold_cnt_d == HoldW'(HOLD_TICKS)) &&
                           (hold_cnt_q != HoldW'(HOLD_TICKS));
        end

        // Hold counter and pulse registers.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                hold_cnt_q   <= '0;
                hold_pulse_q <= 1'b0;
            end else begin
                hold_cnt_q   <= hold_cnt_d;
                hold_pulse_q <= hold_pulse_d;
            end
        end

        assign hold_o = hold_pulse_q;
    end else begin : g_no_hold
        assign hold_o = 1'b0;
    end

    assign level_o   = level_q;
    assign level_d_o = level_d;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/ui_trigger_smoother_bank.sv
// Bank of debounced front-panel inputs sharing one tick prescaler.
module ui_trigger_smoother_bank
    import music_box_ui_pkg::*;
#(
    parameter int unsigned CHANNELS       = UI_NUM_CHANNELS,
    parameter int unsigned CLK_PER_TICK   = UI_CLK_PER_TICK_1MS,
    parameter int unsigned DEBOUNCE_TICKS = UI_DEBOUNCE_TICKS,
    parameter int unsigned HOLD_TICKS     = UI_HOLD_TICKS,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic                clock_50Mhz,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] inputRaw,
    output logic [CHANNELS-1:0] outputLevel,
    output logic [CHANNELS-1:0] pressPulse,
    output logic [CHANNELS-1:0] releasePulse,
    output logic [CHANNELS-1:0] holdPulse,
    output logic                anyPressed,
    output logic                tick
);

    localparam int unsigned PreW = $clog2(CLK_PER_TICK);

    logic [PreW-1:0]     pre_d, pre_q;
    logic [CHANNELS-1:0] level_next;
    logic                any_d, any_q;

    // Prescaler wraps after CLK_PER_TICK-1; tick marks that last count.
    always_comb begin
        tick  = (pre_q == PreW'(CLK_PER_TICK - 1));
        pre_d = tick ? '0 : pre_q + PreW'(1);
        any_d = |level_next;
    end

    // Prescaler and anyPressed registers.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
            any_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            any_q <= any_d;
        end
    end

    assign anyPressed = any_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        ui_debounce_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .HOLD_TICKS     (HOLD_TICKS),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_chan (
            .clk_i     (clock_50Mhz),
            .rst_ni    (reset_n),
            .tick_i    (tick),
            .raw_i     (inputRaw[i]),
            .level_o   (outputLevel[i]),
            .level_d_o (level_next[i]),
            .press_o   (pressPulse[i]),
            .release_o (releasePulse[i]),
            .hold_o    (holdPulse[i])
        );
    end

endmodule

// File: tb/tb_ui_trigger_smoother_bank.sv
// Self-checking bench: directed scenarios plus random stimulus against a
// level/mismatch-run reference model of the smoother bank.
module tb_ui_trigger_smoother_bank;

    localparam int unsigned CH   = 4;
    localparam int unsigned CPT  = 4;
    localparam int unsigned DEB  = 3;
    localparam int unsigned HOLD = 5;
    localparam bit          AL   = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] raw = '1;
    logic [CH-1:0] outputLevel, pressPulse, releasePulse, holdPulse;
    logic          anyPressed, tick;

    always #5 clk = ~clk;

    ui_trigger_smoother_bank #(
        .CHANNELS       (CH),
        .CLK_PER_TICK   (CPT),
        .DEBOUNCE_TICKS (DEB),
        .HOLD_TICKS     (HOLD),
        .ACTIVE_LOW     (AL)
    ) dut (
        .clock_50Mhz  (clk),
        .reset_n      (rst_n),
        .inputRaw     (raw),
        .outputLevel  (outputLevel),
        .pressPulse   (pressPulse),
        .releasePulse (releasePulse),
        .holdPulse    (holdPulse),
        .anyPressed   (anyPressed),
        .tick         (tick)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: confirmed level per channel plus a run of qualifying ticks
    // seen while the synchronised sample has disagreed with it.
    bit      m_s1[CH], m_s2[CH], m_lvl[CH], m_pend[CH];
    int      m_run[CH], m_hcnt[CH];
    int      m_cyc;
    logic [CH-1:0] e_lvl, e_press, e_rel, e_hold;
    logic    e_any, e_tick;

    // Event counters observed from the DUT, for the directed scenario checks.
    int seen_press[CH], seen_rel[CH], seen_hold[CH];
    int seen_1001;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_lvl[c] = 1'b0; m_pend[c] = 1'b0;
            m_run[c] = 0; m_hcnt[c] = 0;
        end
        m_cyc = 0;
        e_lvl = '0; e_press = '0; e_rel = '0; e_hold = '0; e_any = 1'b0; e_tick = 1'b0;
    endtask

    task automatic clear_seen();
        for (int c = 0; c < CH; c++) begin
            seen_press[c] = 0; seen_rel[c] = 0; seen_hold[c] = 0;
        end
        seen_1001 = 0;
    endtask

    // Advance the model by one clock edge using the inputs held before the edge.
    task automatic model_step();
        bit t, s, old_lvl;
        int h_old;
        t = ((m_cyc % CPT) == CPT - 1);
        m_cyc++;
        for (int c = 0; c < CH; c++) begin
            s       = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = raw[c] ^ AL;
            old_lvl = m_lvl[c];
            if (s == m_lvl[c]) begin
                m_pend[c] = 1'b0;
                m_run[c]  = 0;
            end else if (!m_pend[c]) begin
                m_pend[c] = 1'b1;
                m_run[c]  = 0;
            end else if (t) begin
                m_run[c]++;
                if (m_run[c] == DEB) begin
                    m_lvl[c]  = ~m_lvl[c];
                    m_pend[c] = 1'b0;
                    m_run[c]  = 0;
                end
            end
            h_old = m_hcnt[c];
            if (old_lvl && t && m_hcnt[c] < HOLD) m_hcnt[c]++;
            if (!m_lvl[c]) m_hcnt[c] = 0;
            e_hold[c]  = (m_hcnt[c] == HOLD) && (h_old != HOLD);
            e_lvl[c]   = m_lvl[c];
            e_press[c] = m_lvl[c] & ~old_lvl;
            e_rel[c]   = ~m_lvl[c] & old_lvl;
        end
        e_any  = |e_lvl;
        e_tick = ((m_cyc % CPT) == CPT - 1);
    endtask

    task automatic compare_all();
        check_eq("outputLevel", 32'(outputLevel), 32'(e_lvl));
        check_eq("pressPulse", 32'(pressPulse), 32'(e_press));
        check_eq("releasePulse", 32'(releasePulse), 32'(e_rel));
        check_eq("holdPulse", 32'(holdPulse), 32'(e_hold));
        check_eq("anyPressed", 32'(anyPressed), 32'(e_any));
        check_eq("tick", 32'(tick), 32'(e_tick));
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
            for (int c = 0; c < CH; c++) begin
                seen_press[c] += int'(pressPulse[c]);
                seen_rel[c]   += int'(releasePulse[c]);
                seen_hold[c]  += int'(holdPulse[c]);
            end
            if (pressPulse == 4'b1001) seen_1001++;
        end
    endtask

    initial begin
        model_reset();
        clear_seen();
        #20;
        compare_all();
        #2 rst_n = 1'b1;

        // 1: idle after reset, tick cadence
        run_cycles(12);

        // 2: clean press on channel 0
        clear_seen();
        raw[0] = 1'b0;
        run_cycles(20);
        check_eq("p2_press0_once", 32'(seen_press[0]), 32'd1);
        check_eq("p2_level0", 32'(outputLevel[0]), 32'd1);
        check_eq("p2_others_quiet", 32'(seen_press[1] + seen_press[2] + seen_press[3]), 32'd0);

        // 3: glitch on channel 1
        clear_seen();
        raw[1] = 1'b0;
        run_cycles(9);
        raw[1] = 1'b1;
        run_cycles(20);
        check_eq("p3_no_press1", 32'(seen_press[1]), 32'd0);
        check_eq("p3_level1", 32'(outputLevel[1]), 32'd0);

        // 4: hold on channel 2, release, press again
        clear_seen();
        raw[2] = 1'b0;
        run_cycles(40);
        check_eq("p4_hold2_first", 32'(seen_hold[2]), 32'd1);
        run_cycles(30);
        check_eq("p4_hold2_once", 32'(seen_hold[2]), 32'd1);
        raw[2] = 1'b1;
        run_cycles(20);
        check_eq("p4_release2", 32'(seen_rel[2]), 32'd1);
        raw[2] = 1'b0;
        run_cycles(50);
        check_eq("p4_hold2_again", 32'(seen_hold[2]), 32'd2);

        // 5: simultaneous press on 0 and 3, then a one-tick bounce on 3
        raw[0] = 1'b1;
        raw[2] = 1'b1;
        run_cycles(25);
        clear_seen();
        raw[0] = 1'b0;
        raw[3] = 1'b0;
        run_cycles(20);
        check_eq("p5_press_1001", 32'(seen_1001), 32'd1);
        raw[3] = 1'b1;
        run_cycles(4);
        raw[3] = 1'b0;
        run_cycles(25);
        check_eq("p5_no_release3", 32'(seen_rel[3]), 32'd0);
        check_eq("p5_level3", 32'(outputLevel[3]), 32'd1);

        // 6: asynchronous reset while channel 0 is pressed
        #2 rst_n = 1'b0;
        #1;
        check_eq("p6_rst_level", 32'(outputLevel), 32'd0);
        check_eq("p6_rst_release", 32'(releasePulse), 32'd0);
        check_eq("p6_rst_any", 32'(anyPressed), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        clear_seen();
        run_cycles(25);
        check_eq("p6_fresh_press0", 32'(seen_press[0]), 32'd1);
        check_eq("p6_no_release0", 32'(seen_rel[0]), 32'd0);

        // Random segments: patterns held for anything from a glitch to a long press
        for (int seg = 0; seg < 60; seg++) begin
            raw = CH'($urandom_range(0, (1 << CH) - 1));
            run_cycles(int'($urandom_range(1, 45)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ui_trigger_smoother_bank.md
Name: ui_trigger_smoother_bank

Overview:
Parametrised, multi-channel replacement for the per-pin input smoothers on the music box front panel (6 music keys, PlaySong0/1, MakeRecording, PlayRecording). One shared tick prescaler drives a configurable debounce window on every channel. Each channel provides a clean level, one-cycle press and release pulses, and a long-press (hold) pulse. Outputs feed the music-box state controller and the music-keys controller.

Parameters:
CHANNELS, 10, number of independent input channels (≥1)
CLK_PER_TICK, 50000, clock cycles per debounce tick (1 ms at 50 MHz; ≥2)
DEBOUNCE_TICKS, 5, consecutive differing ticks needed to change state (≥1)
HOLD_TICKS, 1000, ticks of continuous press before holdPulse fires; 0 disables hold
ACTIVE_LOW, 1, 1 means a raw input of 0 = pressed; 0 means a raw input of 1 = pressed

Ports:
clock_50Mhz  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
inputRaw  in  CHANNELS  raw GPIO pins, asynchronous to the clock
outputLevel  out  CHANNELS  debounced level, 1 = pressed (polarity normalised)
pressPulse  out  CHANNELS  1-cycle pulse when outputLevel rises
releasePulse  out  CHANNELS  1-cycle pulse when outputLevel falls
holdPulse  out  CHANNELS  1-cycle pulse when press duration reaches HOLD_TICKS
anyPressed  out  1  OR of outputLevel (registered with it)
tick  out  1  prescaler tick, 1 cycle every CLK_PER_TICK cycles

Behaviour:
- Interface: one clock, clock_50Mhz. reset_n is asynchronous and active-low.
- Reset: all outputs are 0. Prescaler count = 0. Per-channel state = IDLE, debounce count = 0, hold count = 0.
- Synchroniser flops reset to the inactive raw value: 1 if ACTIVE_LOW, else 0.
- Reset asserted mid-operation drops everything immediately. Pulses are never emitted because of reset.
- Synchroniser: two flops per channel. The normalised sample s = sync2 XOR ACTIVE_LOW.
- Prescaler:
  - Counter width is $clog2(CLK_PER_TICK). It counts 0..CLK_PER_TICK-1 and wraps.
  - tick = 1 in the cycle the count equals CLK_PER_TICK-1.
  - The first tick after reset occurs at cycle CLK_PER_TICK-1.
- Per-channel FSM, states IDLE, PRESS_PENDING, PRESSED, RELEASE_PENDING:
  - IDLE: if s=1, go to PRESS_PENDING with count=0.
  - PRESS_PENDING:
    - s=0 in any cycle: return to IDLE, count=0 (glitch rejected).
    - On tick with s=1: count+1.
    - When the incremented count equals DEBOUNCE_TICKS: go to PRESSED.
  - PRESSED: if s=0, go to RELEASE_PENDING with count=0.
  - RELEASE_PENDING:
    - s=1 in any cycle: return to PRESSED, count=0. The hold count is kept.
    - On tick with s=0: count+1.
    - When the incremented count equals DEBOUNCE_TICKS: go to IDLE.
- Outputs are registered:
  - outputLevel = 1 in PRESSED and RELEASE_PENDING.
  - pressPulse = 1 in the first cycle outputLevel is 1.
  - releasePulse = 1 in the first cycle outputLevel is 0 after PRESSED.
- Latency: raw edge → sample in 2 cycles. The level changes on the cycle after the DEBOUNCE_TICKS-th qualifying tick.
- Hold (when HOLD_TICKS > 0):
  - The hold counter is $clog2(HOLD_TICKS+1) bits.
  - It increments on tick while outputLevel=1 and saturates at HOLD_TICKS.
  - holdPulse fires once, in the cycle after the count reaches HOLD_TICKS.
  - The counter clears when the channel enters IDLE. holdPulse fires at most once per press.
- Simultaneous events:
  - Channels are fully independent. Any number of pulses may assert in the same cycle.
  - If a qualifying tick coincides with a sample reversal, the reversal wins: the return transition is taken and the count clears.
- The debounce count width is $clog2(DEBOUNCE_TICKS+1). It never wraps; it is cleared on every state change.

Decomposition:
- Package music_box_ui_pkg holds:
  - typedef enum logic[1:0] ui_chan_state_t {IDLE, PRESS_PENDING, PRESSED, RELEASE_PENDING}
  - default constants UI_CLK_PER_TICK_1MS=50000, UI_DEBOUNCE_TICKS=5, UI_HOLD_TICKS=1000
  - channel index constants for the 10 front-panel inputs
- Sub-module ui_debounce_channel holds the synchroniser, FSM, counters and pulse outputs for one channel. The bank instantiates it CHANNELS times in a generate loop and owns the shared prescaler and the anyPressed reduction.

Test Plan:
Bench parameters: CHANNELS=4, CLK_PER_TICK=4, DEBOUNCE_TICKS=3, HOLD_TICKS=5, ACTIVE_LOW=1.
1. Reset release, inputs held at 4'hF:
   - All outputs stay 0.
   - tick pulses at cycles 3, 7, 11, …
2. Clean press on channel 0:
   - Stimulus: inputRaw[0]=0, held.
   - outputLevel[0] rises the cycle after the 3rd qualifying tick.
   - pressPulse[0] is high for exactly 1 cycle.
   - anyPressed=1 and the other channels stay 0.
3. Glitch on channel 1:
   - Stimulus: inputRaw[1] low for 9 cycles (2 ticks), then high.
   - No level change and no pulses.
   - The FSM returns to IDLE.
4. Hold on channel 2:
   - Stimulus: hold low for 40 cycles.
   - holdPulse[2] fires once, 5 ticks after the level rise, and never again.
   - Stimulus: release.
   - releasePulse[2] follows 3 ticks later.
   - Stimulus: press again.
   - holdPulse fires again.
5. Simultaneous edges:
   - Stimulus: channels 0 and 3 pressed in the same cycle.
   - pressPulse=4'b1001 in a single cycle.
   - Stimulus: a 1-tick release bounce on channel 3.
   - Channel 3 stays pressed with no releasePulse.
6. Reset mid-operation:
   - Stimulus: reset_n pulsed low while channel 0 is PRESSED.
   - Outputs go to 0 asynchronously with no releasePulse.
   - After reset, with channel 0 still held low, a fresh pressPulse follows the full 2-cycle + 3-tick latency.
